// File: rtl/vrf_write_arbiter_if.sv
// vrf_write_arbiter_if
// Purpose : bundles the requester-side handshake and the VRF write-port bus
//           of the lane's write arbiter.
// Signals :
//   hold_i       stall; while 1 no grants are issued
//   req_valid_i  per-requester request valid
//   req_ready_o  per-requester grant (combinational)
//   req_addr_i   per-requester write address
//   req_bwe_i    per-requester byte write enables
//   req_data_i   per-requester write data
//   wen_o        per-port VRF write enable (registered)
//   waddr_o      per-port VRF write address (registered)
//   bwe_o        per-port VRF byte enables (registered)
//   din_o        per-port VRF write data (registered)
// Modports: master = requester/stimulus side, slave = arbiter side.
//
// Handshake: requester r transfers in a cycle where req_valid_i[r] and
// req_ready_o[r] are both 1. A requester keeps valid, address, byte enables
// and data stable until that transfer and may only drop valid after it.
// Ready may depend on valid in the same cycle; no requester may wait for
// ready before raising valid.
interface vrf_write_arbiter_if #(
  parameter int REQ_NUM     = 6,
  parameter int W_PORTS_NUM = 4,
  parameter int MEM_DEPTH   = 512,
  parameter int MEM_WIDTH   = 32
);
  localparam int AW = $clog2(MEM_DEPTH);
  localparam int BW = MEM_WIDTH / 8;

  logic                                   hold_i;
  logic [REQ_NUM-1:0]                     req_valid_i;
  logic [REQ_NUM-1:0]                     req_ready_o;
  logic [REQ_NUM-1:0][AW-1:0]             req_addr_i;
  logic [REQ_NUM-1:0][BW-1:0]             req_bwe_i;
  logic [REQ_NUM-1:0][MEM_WIDTH-1:0]      req_data_i;
  logic [W_PORTS_NUM-1:0]                 wen_o;
  logic [W_PORTS_NUM-1:0][AW-1:0]         waddr_o;
  logic [W_PORTS_NUM-1:0][BW-1:0]         bwe_o;
  logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0]  din_o;

  modport master (
    output hold_i, req_valid_i, req_addr_i, req_bwe_i, req_data_i,
    input  req_ready_o, wen_o, waddr_o, bwe_o, din_o
  );

  modport slave (
    input  hold_i, req_valid_i, req_addr_i, req_bwe_i, req_data_i,
    output req_ready_o, wen_o, waddr_o, bwe_o, din_o
  );
endinterface

// File: rtl/vrf_write_arbiter.sv
// vrf_write_arbiter
// Purpose : shares W_PORTS_NUM VRF write ports among REQ_NUM requesters.
//           Each cycle requesters are scanned round-robin starting at the
//           priority pointer; up to W_PORTS_NUM valid requests with mutually
//           distinct addresses are granted and packed onto ports 0, 1, ...
//           The granted payloads reach the VRF one cycle later from registers.
// Ports   :
//   clk       clock, rising edge
//   rstn      asynchronous active-low reset
//   bus       vrf_write_arbiter_if slave modport (requests in, VRF port out)
//   rr_ptr_o  current highest-priority requester index (debug)
module vrf_write_arbiter #(
  parameter int REQ_NUM     = 6,
  parameter int W_PORTS_NUM = 4,
  parameter int MEM_DEPTH   = 512,
  parameter int MEM_WIDTH   = 32,
  localparam int AW = $clog2(MEM_DEPTH),
  localparam int BW = MEM_WIDTH / 8,
  localparam int PW = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  vrf_write_arbiter_if.slave    bus,
  output logic [PW-1:0]         rr_ptr_o
);

  logic [PW-1:0]                          rr_ptr_q;
  logic [PW-1:0]                          rr_ptr_d;
  logic [REQ_NUM-1:0]                     grant;
  // Per-port assignment produced by the scan: which requester sits on port k.
  logic [W_PORTS_NUM-1:0]                 slot_vld;
  logic [W_PORTS_NUM-1:0][PW-1:0]         slot_sel;
  logic [W_PORTS_NUM-1:0][AW-1:0]         slot_addr;

  logic [W_PORTS_NUM-1:0]                 wen_q;
  logic [W_PORTS_NUM-1:0][AW-1:0]         waddr_q;
  logic [W_PORTS_NUM-1:0][BW-1:0]         bwe_q;
  logic [W_PORTS_NUM-1:0][MEM_WIDTH-1:0]  din_q;

  // Round-robin scan. A candidate is granted only if a port is still free
  // and its full address differs from every address already granted this
  // cycle (the LVT/XOR banks cannot merge same-address writes, even with
  // disjoint byte enables). Ready is forced low during reset so a requester
  // never sees a transfer that the cleared registers would drop.
  always_comb begin
    int   idx;
    int   cnt;
    int   last;
    logic hit;
    grant     = '0;
    slot_vld  = '0;
    slot_sel  = '0;
    slot_addr = '0;
    rr_ptr_d  = rr_ptr_q;
    idx       = 0;
    cnt       = 0;
    last      = 0;
    hit       = 1'b0;
    for (int i = 0; i < REQ_NUM; i++) begin
      idx = int'(rr_ptr_q) + i;
      if (idx >= REQ_NUM) idx = idx - REQ_NUM;
      hit = 1'b0;
      for (int k = 0; k < W_PORTS_NUM; k++) begin
        if (k < cnt && slot_addr[k] == bus.req_addr_i[idx]) hit = 1'b1;
      end
      if (rstn && !bus.hold_i && bus.req_valid_i[idx] &&
          cnt < W_PORTS_NUM && !hit) begin
        grant[idx]     = 1'b1;
        slot_vld[cnt]  = 1'b1;
        slot_sel[cnt]  = PW'(idx);
        slot_addr[cnt] = bus.req_addr_i[idx];
        last           = idx;
        cnt            = cnt + 1;
      end
    end
    // Next scan starts just after the last requester served this cycle.
    if (cnt != 0) begin
      rr_ptr_d = (last == REQ_NUM - 1) ? '0 : PW'(last + 1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rr_ptr_q <= '0;
      wen_q    <= '0;
      waddr_q  <= '0;
      bwe_q    <= '0;
      din_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      for (int k = 0; k < W_PORTS_NUM; k++) begin
        wen_q[k] <= slot_vld[k];
        // Idle ports keep their last payload; only the enable drops.
        if (slot_vld[k]) begin
          waddr_q[k] <= bus.req_addr_i[slot_sel[k]];
          bwe_q[k]   <= bus.req_bwe_i[slot_sel[k]];
          din_q[k]   <= bus.req_data_i[slot_sel[k]];
        end
      end
    end
  end

  assign bus.req_ready_o = grant;
  assign bus.wen_o       = wen_q;
  assign bus.waddr_o     = waddr_q;
  assign bus.bwe_o       = bwe_q;
  assign bus.din_o       = din_q;
  assign rr_ptr_o        = rr_ptr_q;

endmodule

// File: tb/tb_vrf_write_arbiter.sv
// tb_vrf_write_arbiter
// Purpose : self-checking bench for vrf_write_arbiter: directed scenarios
//           (reset, saturation, conflict, hold, fairness, zero-bwe wrap)
//           followed by randomised runs against a reference scan model with
//           an expected-payload queue.
module tb_vrf_write_arbiter;
  localparam int REQ_NUM   = 6;
  localparam int W         = 4;
  localparam int MEM_DEPTH = 512;
  localparam int MEM_WIDTH = 32;
  localparam int AW        = 9;
  localparam int BW        = 4;
  localparam int PW        = 3;
  localparam int EW        = AW + BW + MEM_WIDTH;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rstn;
  logic [PW-1:0] rr_ptr_o;

  always #5 clk = ~clk;

  vrf_write_arbiter_if #(.REQ_NUM(REQ_NUM), .W_PORTS_NUM(W),
                         .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH)) bus ();

  vrf_write_arbiter #(.REQ_NUM(REQ_NUM), .W_PORTS_NUM(W),
                      .MEM_DEPTH(MEM_DEPTH), .MEM_WIDTH(MEM_WIDTH)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .bus      (bus),
    .rr_ptr_o (rr_ptr_o)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [AW-1:0] a,
                         input logic [BW-1:0] b, input logic [MEM_WIDTH-1:0] d);
    bus.req_valid_i[r] = 1'b1;
    bus.req_addr_i[r]  = a;
    bus.req_bwe_i[r]   = b;
    bus.req_data_i[r]  = d;
  endtask

  task automatic clear_reqs();
    bus.req_valid_i = '0;
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    clear_reqs();
    bus.hold_i = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  function automatic logic [EW-1:0] port_payload(input int k);
    return {bus.waddr_o[k], bus.bwe_o[k], bus.din_o[k]};
  endfunction

  // ---------------- scoreboard / reference model ----------------
  logic [EW-1:0]      exp_q[$];
  int                 m_ptr;
  logic [REQ_NUM-1:0] m_grant;
  int                 m_n;
  int                 m_ord[W];

  task automatic model_scan();
    logic [AW-1:0] taken[W];
    int r;
    bit clash;
    m_grant = '0;
    m_n     = 0;
    for (int k = 0; k < W; k++) begin
      m_ord[k] = 0;
      taken[k] = '0;
    end
    if (!bus.hold_i) begin
      for (int i = 0; i < REQ_NUM; i++) begin
        r = (m_ptr + i) % REQ_NUM;
        clash = 0;
        for (int j = 0; j < m_n; j++) if (taken[j] == bus.req_addr_i[r]) clash = 1;
        if (bus.req_valid_i[r] && m_n < W && !clash) begin
          m_grant[r]  = 1'b1;
          taken[m_n]  = bus.req_addr_i[r];
          m_ord[m_n]  = r;
          m_n++;
        end
      end
    end
    if (m_n > 0) m_ptr = (m_ord[m_n-1] + 1) % REQ_NUM;
  endtask

  task automatic run_random(input int cycles, input bit distinct);
    logic [REQ_NUM-1:0] seen;
    logic [W-1:0]       ew;
    int                 waitc[REQ_NUM];
    int                 max_wait;
    int                 dup;
    max_wait = 0;
    for (int r = 0; r < REQ_NUM; r++) waitc[r] = 0;
    m_ptr = 0;
    exp_q.delete();
    for (int c = 0; c < cycles; c++) begin
      for (int r = 0; r < REQ_NUM; r++) begin
        if (!bus.req_valid_i[r] && $urandom_range(0, 3) != 0) begin
          set_req(r,
                  distinct ? AW'(r * 64 + $urandom_range(0, 63)) : AW'($urandom_range(0, 7)),
                  BW'($urandom_range(0, 15)), $urandom);
        end
      end
      bus.hold_i = ($urandom_range(0, 7) == 0);
      #1;
      check("rnd_ptr", rr_ptr_o, m_ptr);
      model_scan();
      check("rnd_ready", bus.req_ready_o, m_grant);
      for (int i = 0; i < m_n; i++) begin
        exp_q.push_back({bus.req_addr_i[m_ord[i]], bus.req_bwe_i[m_ord[i]],
                         bus.req_data_i[m_ord[i]]});
      end
      seen = bus.req_ready_o;
      for (int r = 0; r < REQ_NUM; r++) begin
        if (bus.req_valid_i[r]) begin
          if (seen[r]) begin
            if (waitc[r] > max_wait) max_wait = waitc[r];
            waitc[r] = 0;
          end else if (!bus.hold_i) begin
            waitc[r]++;
          end
        end
      end
      tick();
      ew = '0;
      for (int k = 0; k < m_n; k++) ew[k] = 1'b1;
      check("rnd_wen", bus.wen_o, ew);
      for (int k = 0; k < m_n; k++) begin
        if (exp_q.size() > 0) check("rnd_port", port_payload(k), exp_q.pop_front());
        else check("rnd_port_q_underflow", 1, 0);
      end
      dup = 0;
      for (int a = 0; a < W; a++)
        for (int b = a + 1; b < W; b++)
          if (bus.wen_o[a] && bus.wen_o[b] && bus.waddr_o[a] == bus.waddr_o[b]) dup++;
      check("rnd_addr_unique", dup, 0);
      for (int r = 0; r < REQ_NUM; r++) if (seen[r]) bus.req_valid_i[r] = 1'b0;
    end
    check("rnd_exp_q_empty", exp_q.size(), 0);
    if (distinct) check("rnd_max_wait_ok", (max_wait <= REQ_NUM) ? 1 : 0, 1);
    clear_reqs();
    bus.hold_i = 1'b0;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin : main
    int waited;
    rstn            = 1'b0;
    bus.hold_i      = 1'b0;
    bus.req_valid_i = '0;
    bus.req_addr_i  = '0;
    bus.req_bwe_i   = '0;
    bus.req_data_i  = '0;
    tick();
    tick();
    check("rst_wen", bus.wen_o, 0);
    check("rst_waddr", bus.waddr_o, 0);
    check("rst_ptr", rr_ptr_o, 0);
    rstn = 1'b1;

    // Reset asserted mid-cycle with three live requests.
    set_req(0, 9'd1, 4'hF, 32'hD000_0000);
    set_req(1, 9'd2, 4'hF, 32'hD000_0001);
    set_req(2, 9'd3, 4'hF, 32'hD000_0002);
    #1;
    check("t1_ready", bus.req_ready_o, 6'b000111);
    tick();
    check("t1_wen", bus.wen_o, 4'b0111);
    check("t1_ptr", rr_ptr_o, 3);
    #2;
    rstn = 1'b0;
    #1;
    check("t1_rst_wen", bus.wen_o, 0);
    check("t1_rst_ready", bus.req_ready_o, 0);
    check("t1_rst_ptr", rr_ptr_o, 0);
    check("t1_rst_din", bus.din_o, 0);
    tick();
    rstn = 1'b1;
    #1;
    check("t1_post_ready", bus.req_ready_o, 6'b000111);
    tick();
    check("t1_post_wen", bus.wen_o, 4'b0111);
    check("t1_post_p0", port_payload(0), {9'd1, 4'hF, 32'hD000_0000});
    check("t1_post_p2", port_payload(2), {9'd3, 4'hF, 32'hD000_0002});
    check("t1_post_ptr", rr_ptr_o, 3);

    // Saturation and rotation.
    do_reset();
    for (int r = 0; r < REQ_NUM; r++) set_req(r, AW'(10 + r), 4'hF, 32'hA0 + r);
    #1;
    check("t2_ready0", bus.req_ready_o, 6'b001111);
    tick();
    check("t2_wen0", bus.wen_o, 4'b1111);
    check("t2_p3", port_payload(3), {9'd13, 4'hF, 32'hA3});
    check("t2_ptr0", rr_ptr_o, 4);
    bus.req_valid_i[3:0] = 4'b0000;
    #1;
    check("t2_ready1", bus.req_ready_o, 6'b110000);
    tick();
    check("t2_wen1", bus.wen_o, 4'b0011);
    check("t2_p0", bus.waddr_o[0], 14);
    check("t2_p1", port_payload(1), {9'd15, 4'hF, 32'hA5});
    check("t2_ptr1", rr_ptr_o, 0);
    clear_reqs();
    tick();
    check("t2_idle_wen", bus.wen_o, 0);

    // Same-address conflict, pointer at 0.
    set_req(1, 9'h2A, 4'h3, 32'h1111_1111);
    set_req(3, 9'h2A, 4'hC, 32'h3333_3333);
    #1;
    check("t3_ready0", bus.req_ready_o, 6'b000010);
    tick();
    check("t3_wen0", bus.wen_o, 4'b0001);
    check("t3_p0_0", port_payload(0), {9'h2A, 4'h3, 32'h1111_1111});
    check("t3_ptr0", rr_ptr_o, 2);
    bus.req_valid_i[1] = 1'b0;
    #1;
    check("t3_ready1", bus.req_ready_o, 6'b001000);
    tick();
    check("t3_wen1", bus.wen_o, 4'b0001);
    check("t3_p0_1", port_payload(0), {9'h2A, 4'hC, 32'h3333_3333});
    check("t3_ptr1", rr_ptr_o, 4);
    clear_reqs();
    tick();

    // Hold for three cycles with the pointer at 4.
    set_req(0, 9'd20, 4'hF, 32'h20);
    set_req(1, 9'd21, 4'hF, 32'h21);
    bus.hold_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_hold_ready", bus.req_ready_o, 0);
      tick();
      check("t4_hold_wen", bus.wen_o, 0);
      check("t4_hold_ptr", rr_ptr_o, 4);
    end
    bus.hold_i = 1'b0;
    #1;
    check("t4_rel_ready", bus.req_ready_o, 6'b000011);
    tick();
    check("t4_rel_wen", bus.wen_o, 4'b0011);
    check("t4_rel_p0", bus.waddr_o[0], 20);
    check("t4_rel_p1", bus.waddr_o[1], 21);
    check("t4_rel_ptr", rr_ptr_o, 2);
    clear_reqs();
    tick();

    // Fairness: requester 5 competes with 0..3 for four ports.
    do_reset();
    for (int r = 0; r < 4; r++) set_req(r, AW'(40 + r), 4'hF, 32'h40 + r);
    set_req(5, 9'd45, 4'hF, 32'h45);
    #1;
    check("t5_ready0", bus.req_ready_o, 6'b001111);
    tick();
    check("t5_ptr0", rr_ptr_o, 4);
    waited = 0;
    while (!bus.req_ready_o[5] && waited < REQ_NUM) begin
      tick();
      waited++;
    end
    check("t5_req5_granted", bus.req_ready_o[5], 1);
    check("t5_ready1", bus.req_ready_o, 6'b100111);
    tick();
    check("t5_wen1", bus.wen_o, 4'b1111);
    check("t5_p0", port_payload(0), {9'd45, 4'hF, 32'h45});
    check("t5_ptr1", rr_ptr_o, 3);
    clear_reqs();
    tick();

    // Zero byte enables at index 5 with pointer wrap.
    do_reset();
    set_req(4, 9'd7, 4'hF, 32'h7);
    #1;
    check("t6_ready4", bus.req_ready_o, 6'b010000);
    tick();
    check("t6_ptr5", rr_ptr_o, 5);
    clear_reqs();
    set_req(5, 9'h1FF, 4'h0, 32'hDEAD_BEEF);
    #1;
    check("t6_ready5", bus.req_ready_o, 6'b100000);
    tick();
    check("t6_wen", bus.wen_o, 4'b0001);
    check("t6_bwe0", bus.bwe_o[0], 0);
    check("t6_p0", port_payload(0), {9'h1FF, 4'h0, 32'hDEAD_BEEF});
    check("t6_ptr_wrap", rr_ptr_o, 0);
    clear_reqs();
    tick();

    // Randomised runs: conflicting small address space, then disjoint
    // per-requester address ranges for the wait bound.
    do_reset();
    run_random(300, 1'b0);
    do_reset();
    run_random(300, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
